adbg_lint_arb: RTL and testbench
================================

Name: adbg_lint_arb

Overview:
- Round-robin arbiter that shares one LINT master port (req/gnt/r_valid protocol) between NB_REQ requesters, e.g. the debug BIU and a system-bus DMA/trace unit.
- Forwards the winning requester's address, write data, byte enables and write enable unchanged.
- Keeps an in-order FIFO of granted requester IDs so each read/write response goes back to the requester that issued it.
- Sits in the clk_i domain, between the LINT masters and the interconnect.

Parameters:
- NB_REQ, 2: number of requesters (2..8).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 64: data width (32 or 64).
- MAX_OUTST, 4: maximum outstanding granted transactions (power of 2, at least 2).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset: one clock; reset is synchronous and active-low.
- req_i  in  NB_REQ  per-requester request.
- add_i  in  NB_REQ x ADDR_WIDTH  per-requester address.
- wen_i  in  NB_REQ  per-requester write enable, active-low (0 = write).
- wdata_i  in  NB_REQ x DATA_WIDTH  per-requester write data.
- be_i  in  NB_REQ x DATA_WIDTH/8  per-requester byte enables.
- gnt_o  out  NB_REQ  per-requester grant.
- r_valid_o  out  NB_REQ  per-requester response valid.
- r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- lint_req_o  out  1  master request.
- lint_add_o  out  ADDR_WIDTH  master address.
- lint_wen_o  out  1  master write enable, active-low.
- lint_wdata_o  out  DATA_WIDTH  master write data.
- lint_be_o  out  DATA_WIDTH/8  master byte enables.
- lint_gnt_i  in  1  master grant.
- lint_r_valid_i  in  1  master response valid.
- lint_r_rdata_i  in  DATA_WIDTH  master response data.
- err_o  out  1  sticky error: a response arrived with no transaction outstanding.

Behaviour:
- Reset (rstn_i low at a clk_i edge):
  - rr_ptr = 0, ID FIFO empty, err_o = 0.
  - Outputs are combinational from that state: lint_req_o = 0, gnt_o = 0, r_valid_o = 0.
  - A reset mid-transaction discards all outstanding IDs; any later response is counted as spurious (see below).
- Arbitration (combinational, zero latency):
  - Winner = first asserted req_i scanning rr_ptr, rr_ptr+1, ... modulo NB_REQ.
  - lint_req_o = (any req_i) AND NOT fifo_full.
  - Master data/address/wen/be outputs carry the winner's inputs. With no request they carry requester 0's inputs with lint_req_o = 0.
  - gnt_o[winner] = lint_gnt_i AND lint_req_o. All other gnt_o bits are 0.
  - Requesters hold req and payload until granted (LINT rule). The arbiter may re-arbitrate every cycle until a grant occurs; no lock-in before grant.
- On an accepted grant (lint_req_o AND lint_gnt_i):
  - push the winner ID into the FIFO;
  - set rr_ptr = (winner + 1) mod NB_REQ.
  - rr_ptr is unchanged without an accepted grant.
- Response routing:
  - On lint_r_valid_i with FIFO non-empty: r_valid_o[head] = 1 in the same cycle, r_rdata_o = lint_r_rdata_i, pop head.
  - r_rdata_o always equals lint_r_rdata_i.
- Full: when the FIFO holds MAX_OUTST entries, lint_req_o = 0, even if a response pops in the same cycle (deterministic, no combinational path from r_valid to req).
- Simultaneous push and pop when not full: both take effect; count is unchanged.
- Spurious response (lint_r_valid_i with FIFO empty): no r_valid_o asserted, err_o is set and stays 1 until reset.
- A single requester may have several outstanding transactions; responses return in grant order.

Optional Feature:
- Macro ADBG_LINT_ARB_FIXED_PRIO0_EN.
- Defined: requester 0 is fixed highest priority. If req_i[0] is asserted it wins regardless of rr_ptr. The remaining requesters round-robin among themselves, and rr_ptr never points at 0.
- Undefined: pure round-robin over all NB_REQ requesters.

Decomposition:
- Package adbg_lint_pkg:
  - typedef lint_req_t (add, wen, wdata, be) parameterised by the widths;
  - localparam ID_WIDTH = $clog2(NB_REQ);
  - localparam CNT_WIDTH = $clog2(MAX_OUTST)+1.
- Sub-module adbg_lint_id_fifo: synchronous FIFO of ID_WIDTH x MAX_OUTST with push, pop, full, empty and head outputs; rd/wr pointers and a count register.
- Arbiter top: round-robin pointer, winner select, mux and routing.

Test Plan:
- Single read, NB_REQ=2: req_i=2'b01, add 0x1000, gnt held 1 → lint_req_o=1, gnt_o=01. Response 0xDEADBEEF_00000001 one cycle later → r_valid_o=01, r_rdata_o=0xDEADBEEF_00000001.
- Fairness, both requesters requesting continuously with lint_gnt_i=1 → grant sequence 0,1,0,1 over 4 cycles; rr_ptr alternates.
- Grant stall: lint_gnt_i=0 for 3 cycles, then 1 → the same winner is held on the master outputs; exactly one gnt_o pulse.
- Full, MAX_OUTST=4: 4 grants with no responses → lint_req_o=0 on the 5th cycle, including a cycle where a response also arrives. The next cycle after that pop, lint_req_o=1.
- Ordering: grants to IDs 1,0,1, then 3 responses A,B,C → r_valid_o pulses 10,01,10 carrying A,B,C respectively.
- Spurious response after reset → no r_valid_o, err_o=1 and held. With ADBG_LINT_ARB_FIXED_PRIO0_EN defined: req_i=11 continuously → requester 0 wins every cycle.

Source files
------------

// File: rtl/adbg_lint_pkg.sv
// -----------------------------------------------------------------------------
// adbg_lint_pkg
// Shared types and constants for the LINT round-robin arbiter slice.
//   DEF_*       default parameter values of adbg_lint_arb
//   ID_WIDTH    requester-ID width at the default configuration
//   CNT_WIDTH   occupancy-counter width at the default configuration
//   lint_req_t  one LINT request payload (add, wen, wdata, be) at default widths
//   id_width()  requester-ID width for an arbitrary requester count
//   cnt_width() occupancy-counter width for an arbitrary FIFO depth
// -----------------------------------------------------------------------------
package adbg_lint_pkg;

   localparam int DEF_NB_REQ     = 2;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_MAX_OUTST  = 4;

   localparam int ID_WIDTH  = $clog2(DEF_NB_REQ);
   localparam int CNT_WIDTH = $clog2(DEF_MAX_OUTST) + 1;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0]   add;
      logic                        wen;
      logic [DEF_DATA_WIDTH-1:0]   wdata;
      logic [DEF_DATA_WIDTH/8-1:0] be;
   } lint_req_t;

   // An ID must be at least one bit wide even for degenerate counts.
   function automatic int id_width(input int nb_req);
      return (nb_req > 1) ? $clog2(nb_req) : 1;
   endfunction

   // One extra bit so the counter can represent "completely full".
   function automatic int cnt_width(input int max_outst);
      return $clog2(max_outst) + 1;
   endfunction

endpackage

// File: rtl/adbg_lint_id_fifo.sv
// -----------------------------------------------------------------------------
// adbg_lint_id_fifo
// In-order FIFO of granted requester IDs; the head names the requester that
// owns the next response.
//   clk_i, rstn_i  clock, synchronous active-low reset (empties the FIFO)
//   push, push_id  enqueue push_id (ignored when full)
//   pop            dequeue the head (ignored when empty)
//   full, empty    occupancy flags
//   head           ID at the front of the queue
// -----------------------------------------------------------------------------
module adbg_lint_id_fifo
   import adbg_lint_pkg::*;
#(
   parameter int ID_W  = 1,
   parameter int DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            push,
   input  logic [ID_W-1:0] push_id,
   input  logic            pop,
   output logic            full,
   output logic            empty,
   output logic [ID_W-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [ID_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only ever read
   // after it has been written, so resetting it would only cost reset fan-out.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/adbg_lint_arb.sv
// -----------------------------------------------------------------------------
// adbg_lint_arb
// Round-robin arbiter sharing one LINT master port between NB_REQ requesters.
// Grants are zero-latency; granted IDs are queued so responses return to the
// requester that issued them, in grant order.
//   clk_i, rstn_i            clock, synchronous active-low reset
//   req_i/add_i/wen_i/
//   wdata_i/be_i             per-requester LINT request side
//   gnt_o, r_valid_o         per-requester grant and response valid
//   r_rdata_o                response data, broadcast to all requesters
//   lint_*_o / lint_*_i      shared LINT master port
//   err_o                    sticky: response arrived with nothing outstanding
// Optional macro ADBG_LINT_ARB_FIXED_PRIO0_EN: requester 0 always wins when it
// requests; requesters 1..NB_REQ-1 round-robin among themselves.
// -----------------------------------------------------------------------------
module adbg_lint_arb
   import adbg_lint_pkg::*;
#(
   parameter int NB_REQ     = DEF_NB_REQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_OUTST  = DEF_MAX_OUTST
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  logic [NB_REQ-1:0]                    req_i,
   input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
   input  logic [NB_REQ-1:0]                    wen_i,
   input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
   input  logic [NB_REQ-1:0][DATA_WIDTH/8-1:0]  be_i,
   output logic [NB_REQ-1:0]                    gnt_o,
   output logic [NB_REQ-1:0]                    r_valid_o,
   output logic [DATA_WIDTH-1:0]                r_rdata_o,
   output logic                                 lint_req_o,
   output logic [ADDR_WIDTH-1:0]                lint_add_o,
   output logic                                 lint_wen_o,
   output logic [DATA_WIDTH-1:0]                lint_wdata_o,
   output logic [DATA_WIDTH/8-1:0]              lint_be_o,
   input  logic                                 lint_gnt_i,
   input  logic                                 lint_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                lint_r_rdata_i,
   output logic                                 err_o
);

   localparam int ID_W = id_width(NB_REQ);

`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
   // Requester 0 is outside the rotation, so the pointer starts at 1.
   localparam logic [ID_W-1:0] RR_RESET = ID_W'(1);
`else
   localparam logic [ID_W-1:0] RR_RESET = '0;
`endif

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   add;
      logic                    wen;
      logic [DATA_WIDTH-1:0]   wdata;
      logic [DATA_WIDTH/8-1:0] be;
   } payload_t;

   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] rr_next;
   logic [ID_W-1:0] winner;
   logic            found;
   int              scan_idx;
   int              next_idx;
   payload_t        sel;
   logic            accept;
   logic            fifo_full;
   logic            fifo_empty;
   logic [ID_W-1:0] fifo_head;
   logic            resp_pop;

   // Winner scan starting at rr_ptr; defaults to requester 0 when idle so the
   // master port carries requester 0's payload with lint_req_o low.
   // NOTE: every signal assigned in this always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = 0;
`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
      if (req_i[0]) found = 1'b1;
      for (int k = 0; k < NB_REQ - 1; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NB_REQ) scan_idx = scan_idx - (NB_REQ - 1);
         if (!found && req_i[ID_W'(scan_idx)]) begin
            winner = ID_W'(scan_idx);
            found  = 1'b1;
         end
      end
`else
      for (int k = 0; k < NB_REQ; k++) begin
         scan_idx = int'(rr_ptr) + k;
         if (scan_idx >= NB_REQ) scan_idx = scan_idx - NB_REQ;
         if (!found && req_i[ID_W'(scan_idx)]) begin
            winner = ID_W'(scan_idx);
            found  = 1'b1;
         end
      end
`endif
   end

   // Pointer moves just past the winner of an accepted grant.
   always_comb begin
      next_idx = int'(winner) + 1;
`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
      if (next_idx >= NB_REQ) next_idx = 1;
`else
      if (next_idx >= NB_REQ) next_idx = 0;
`endif
      rr_next = ID_W'(next_idx);
   end

   always_comb begin
      sel = '{add: add_i[winner], wen: wen_i[winner],
              wdata: wdata_i[winner], be: be_i[winner]};
   end

   // Full blocks the request even if a response pops this cycle: keeps
   // r_valid off the combinational path to req.
   assign lint_req_o   = (|req_i) && !fifo_full;
   assign lint_add_o   = sel.add;
   assign lint_wen_o   = sel.wen;
   assign lint_wdata_o = sel.wdata;
   assign lint_be_o    = sel.be;
   assign accept       = lint_req_o && lint_gnt_i;
   assign resp_pop     = lint_r_valid_i && !fifo_empty;
   assign r_rdata_o    = lint_r_rdata_i;

   always_comb begin
      gnt_o     = '0;
      r_valid_o = '0;
      if (accept)   gnt_o[winner]        = 1'b1;
      if (resp_pop) r_valid_o[fifo_head] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rr_ptr <= RR_RESET;
         err_o  <= 1'b0;
      end else begin
         if (accept) rr_ptr <= rr_next;
         if (lint_r_valid_i && fifo_empty) err_o <= 1'b1;
      end
   end

   adbg_lint_id_fifo #(
      .ID_W  (ID_W),
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push    (accept),
      .push_id (winner),
      .pop     (resp_pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

endmodule

// File: tb/tb_adbg_lint_arb.sv
// -----------------------------------------------------------------------------
// tb_adbg_lint_arb
// Self-checking bench for adbg_lint_arb at NB_REQ=2, DATA_WIDTH=64,
// MAX_OUTST=4. A reference model (queue of outstanding IDs, a rotation
// pointer and a sticky error bit) predicts every DUT output.
// -----------------------------------------------------------------------------
module tb_adbg_lint_arb;

   localparam int NB = 2;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int BW = DW / 8;
   localparam int MO = 4;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [NB-1:0]          req;
   logic [NB-1:0][AW-1:0]  add;
   logic [NB-1:0]          wen;
   logic [NB-1:0][DW-1:0]  wdata;
   logic [NB-1:0][BW-1:0]  be;
   logic [NB-1:0]          gnt_o;
   logic [NB-1:0]          r_valid_o;
   logic [DW-1:0]          r_rdata_o;
   logic                   lint_req_o;
   logic [AW-1:0]          lint_add_o;
   logic                   lint_wen_o;
   logic [DW-1:0]          lint_wdata_o;
   logic [BW-1:0]          lint_be_o;
   logic                   lint_gnt;
   logic                   lint_rv;
   logic [DW-1:0]          lint_rdata;
   logic                   err_o;

   adbg_lint_arb #(
      .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
   ) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .req_i          (req),
      .add_i          (add),
      .wen_i          (wen),
      .wdata_i        (wdata),
      .be_i           (be),
      .gnt_o          (gnt_o),
      .r_valid_o      (r_valid_o),
      .r_rdata_o      (r_rdata_o),
      .lint_req_o     (lint_req_o),
      .lint_add_o     (lint_add_o),
      .lint_wen_o     (lint_wen_o),
      .lint_wdata_o   (lint_wdata_o),
      .lint_be_o      (lint_be_o),
      .lint_gnt_i     (lint_gnt),
      .lint_r_valid_i (lint_rv),
      .lint_r_rdata_i (lint_rdata),
      .err_o          (err_o)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state.
   int q[$];
   int rr;
   bit m_err;
   // Model predictions for the current cycle.
   logic          exp_req;
   int            exp_win;
   logic [NB-1:0] exp_gnt;
   logic [NB-1:0] exp_rv;
   bit            exp_push;
   bit            exp_pop;

`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
   localparam int RR_START = 1;
`else
   localparam int RR_START = 0;
`endif

   task automatic model_eval();
      bit found;
      int idx;
      found   = 0;
      exp_win = 0;
`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
      if (req[0]) found = 1;
      for (int k = 0; k < NB - 1; k++) begin
         idx = 1 + ((rr - 1 + k) % (NB - 1));
         if (!found && req[idx]) begin exp_win = idx; found = 1; end
      end
`else
      for (int k = 0; k < NB; k++) begin
         idx = (rr + k) % NB;
         if (!found && req[idx]) begin exp_win = idx; found = 1; end
      end
`endif
      exp_req  = (req != '0) && (q.size() < MO);
      exp_push = exp_req && lint_gnt;
      exp_gnt  = '0;
      if (exp_push) exp_gnt[exp_win] = 1'b1;
      exp_pop  = lint_rv && (q.size() > 0);
      exp_rv   = '0;
      if (exp_pop) exp_rv[q[0]] = 1'b1;
   endtask

   // Advance one clock and update the model with what the edge commits.
   task automatic tick();
      int nxt;
      model_eval();
      @(posedge clk);
      if (!rstn) begin
         q.delete();
         rr    = RR_START;
         m_err = 0;
      end else begin
         if (lint_rv && q.size() == 0) m_err = 1;
         if (exp_pop) void'(q.pop_front());
         if (exp_push) begin
            q.push_back(exp_win);
            nxt = (exp_win + 1) % NB;
`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
            if (nxt == 0) nxt = 1;
`endif
            rr = nxt;
         end
      end
      #1;
   endtask

   task automatic randomize_payload();
      for (int i = 0; i < NB; i++) begin
         add[i]   = $urandom;
         wen[i]   = 1'($urandom);
         wdata[i] = {$urandom, $urandom};
         be[i]    = BW'($urandom);
      end
      add[1] = add[0] ^ 32'h0000_1000;
   endtask

   task automatic drain();
      int budget;
      budget = 4 * MO;
      req = '0; lint_gnt = 1'b0; lint_rv = 1'b1;
      while (q.size() > 0 && budget > 0) begin
         lint_rdata = {$urandom, $urandom};
         #1; model_eval();
         n_total++;
         if (r_valid_o !== exp_rv) $display("FAIL drain r_valid: got %b exp %b", r_valid_o, exp_rv);
         else n_pass++;
         tick();
         budget--;
      end
      lint_rv = 1'b0;
      n_total++;
      if (q.size() != 0) $display("FAIL drain budget: %0d entries left, exp 0", q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      rstn = 1'b0; req = '1; lint_gnt = 1'b1; lint_rv = 1'b0; lint_rdata = '0;
      randomize_payload();
      tick(); tick();
      rstn = 1'b1; req = '0; lint_gnt = 1'b0;
      #1;
      n_total++; if (lint_req_o !== 1'b0) $display("FAIL reset lint_req: got %b exp 0", lint_req_o); else n_pass++;
      n_total++; if (gnt_o !== '0) $display("FAIL reset gnt: got %b exp 00", gnt_o); else n_pass++;
      n_total++; if (r_valid_o !== '0) $display("FAIL reset r_valid: got %b exp 00", r_valid_o); else n_pass++;
      n_total++; if (err_o !== 1'b0) $display("FAIL reset err: got %b exp 0", err_o); else n_pass++;
      n_total++; if (lint_add_o !== add[0]) $display("FAIL reset idle_add: got %h exp %h", lint_add_o, add[0]); else n_pass++;
      tick();
   endtask

   task automatic test_single_read();
      add[0] = 32'h0000_1000; wen[0] = 1'b1; req = 2'b01; lint_gnt = 1'b1;
      #1;
      n_total++; if (lint_req_o !== 1'b1) $display("FAIL single lint_req: got %b exp 1", lint_req_o); else n_pass++;
      n_total++; if (gnt_o !== 2'b01) $display("FAIL single gnt: got %b exp 01", gnt_o); else n_pass++;
      n_total++; if (lint_add_o !== 32'h1000) $display("FAIL single add: got %h exp 00001000", lint_add_o); else n_pass++;
      n_total++; if (lint_wen_o !== 1'b1) $display("FAIL single wen: got %b exp 1", lint_wen_o); else n_pass++;
      tick();
      req = '0; lint_gnt = 1'b0; lint_rv = 1'b1; lint_rdata = 64'hDEAD_BEEF_0000_0001;
      #1;
      n_total++; if (r_valid_o !== 2'b01) $display("FAIL single r_valid: got %b exp 01", r_valid_o); else n_pass++;
      n_total++; if (r_rdata_o !== 64'hDEAD_BEEF_0000_0001) $display("FAIL single rdata: got %h exp deadbeef00000001", r_rdata_o); else n_pass++;
      tick();
      lint_rv = 1'b0;
   endtask

   task automatic test_fairness();
      req = 2'b11; lint_gnt = 1'b1; lint_rv = 1'b0;
      randomize_payload();
      for (int c = 0; c < 4; c++) begin
         #1; model_eval();
         n_total++; if (gnt_o !== exp_gnt) $display("FAIL fair gnt c%0d: got %b exp %b", c, gnt_o, exp_gnt); else n_pass++;
         n_total++; if (lint_add_o !== add[exp_win]) $display("FAIL fair add c%0d: got %h exp %h", c, lint_add_o, add[exp_win]); else n_pass++;
         tick();
      end
      drain();
   endtask

   task automatic test_grant_stall();
      int stall_win;
      int pulses;
      pulses = 0;
      req = 2'b11; lint_gnt = 1'b0;
      randomize_payload();
      #1; model_eval();
      stall_win = exp_win;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) #1;
         n_total++; if (lint_req_o !== 1'b1) $display("FAIL stall lint_req c%0d: got %b exp 1", c, lint_req_o); else n_pass++;
         n_total++; if (lint_add_o !== add[stall_win]) $display("FAIL stall add c%0d: got %h exp %h", c, lint_add_o, add[stall_win]); else n_pass++;
         if (gnt_o != '0) pulses++;
         tick();
      end
      lint_gnt = 1'b1;
      #1;
      n_total++; if (gnt_o[stall_win] !== 1'b1) $display("FAIL stall gnt: got %b exp winner %0d", gnt_o, stall_win); else n_pass++;
      if (gnt_o != '0) pulses++;
      tick();
      req = '0; lint_gnt = 1'b0;
      #1;
      if (gnt_o != '0) pulses++;
      n_total++; if (pulses != 1) $display("FAIL stall pulses: got %0d exp 1", pulses); else n_pass++;
      tick();
      drain();
   endtask

   task automatic test_full();
      lint_gnt = 1'b1; lint_rv = 1'b0;
      for (int c = 0; c < MO; c++) begin
         req = NB'($urandom_range(1, 3));
         #1; model_eval();
         n_total++; if (gnt_o !== exp_gnt) $display("FAIL full fill gnt c%0d: got %b exp %b", c, gnt_o, exp_gnt); else n_pass++;
         tick();
      end
      req = 2'b11;
      #1;
      n_total++; if (lint_req_o !== 1'b0) $display("FAIL full lint_req: got %b exp 0", lint_req_o); else n_pass++;
      n_total++; if (gnt_o !== '0) $display("FAIL full gnt: got %b exp 00", gnt_o); else n_pass++;
      tick();
      lint_rv = 1'b1; lint_rdata = {$urandom, $urandom};
      #1; model_eval();
      n_total++; if (lint_req_o !== 1'b0) $display("FAIL full_pop lint_req: got %b exp 0", lint_req_o); else n_pass++;
      n_total++; if (r_valid_o !== exp_rv) $display("FAIL full_pop r_valid: got %b exp %b", r_valid_o, exp_rv); else n_pass++;
      tick();
      lint_rv = 1'b0;
      #1;
      n_total++; if (lint_req_o !== 1'b1) $display("FAIL after_pop lint_req: got %b exp 1", lint_req_o); else n_pass++;
      tick();
      drain();
   endtask

   task automatic test_ordering();
      logic [NB-1:0] exp_seq [3];
      logic [DW-1:0] data [3];
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
      data[0] = 64'hAAAA_0000_1111_0001;
      data[1] = 64'hBBBB_0000_2222_0002;
      data[2] = 64'hCCCC_0000_3333_0003;
      lint_gnt = 1'b1;
      req = 2'b10; #1; tick();
      req = 2'b01; #1; tick();
      req = 2'b10; #1; tick();
      req = '0; lint_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lint_rv = 1'b1; lint_rdata = data[i];
         #1;
         n_total++; if (r_valid_o !== exp_seq[i]) $display("FAIL order r_valid %0d: got %b exp %b", i, r_valid_o, exp_seq[i]); else n_pass++;
         n_total++; if (r_rdata_o !== data[i]) $display("FAIL order rdata %0d: got %h exp %h", i, r_rdata_o, data[i]); else n_pass++;
         tick();
      end
      lint_rv = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         randomize_payload();
         req        = NB'($urandom);
         lint_gnt   = ($urandom_range(0, 3) != 0);
         lint_rv    = (q.size() > 0) && ($urandom_range(0, 2) == 0);
         lint_rdata = {$urandom, $urandom};
         #1; model_eval();
         n_total++; if (lint_req_o !== exp_req) $display("FAIL rnd lint_req c%0d: got %b exp %b", c, lint_req_o, exp_req); else n_pass++;
         n_total++; if (gnt_o !== exp_gnt) $display("FAIL rnd gnt c%0d: got %b exp %b", c, gnt_o, exp_gnt); else n_pass++;
         n_total++; if (r_valid_o !== exp_rv) $display("FAIL rnd r_valid c%0d: got %b exp %b", c, r_valid_o, exp_rv); else n_pass++;
         n_total++; if (r_rdata_o !== lint_rdata) $display("FAIL rnd rdata c%0d: got %h exp %h", c, r_rdata_o, lint_rdata); else n_pass++;
         n_total++; if (lint_add_o !== add[exp_win]) $display("FAIL rnd add c%0d: got %h exp %h", c, lint_add_o, add[exp_win]); else n_pass++;
         n_total++; if (lint_wdata_o !== wdata[exp_win]) $display("FAIL rnd wdata c%0d: got %h exp %h", c, lint_wdata_o, wdata[exp_win]); else n_pass++;
         n_total++; if (lint_be_o !== be[exp_win]) $display("FAIL rnd be c%0d: got %h exp %h", c, lint_be_o, be[exp_win]); else n_pass++;
         n_total++; if (lint_wen_o !== wen[exp_win]) $display("FAIL rnd wen c%0d: got %b exp %b", c, lint_wen_o, wen[exp_win]); else n_pass++;
         n_total++; if (err_o !== m_err) $display("FAIL rnd err c%0d: got %b exp %b", c, err_o, m_err); else n_pass++;
         tick();
      end
      drain();
   endtask

`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
   task automatic test_fixed_prio();
      req = 2'b11; lint_gnt = 1'b1;
      for (int c = 0; c < 4; c++) begin
         lint_rv = (q.size() > 0);
         #1;
         n_total++; if (gnt_o !== 2'b01) $display("FAIL prio0 gnt c%0d: got %b exp 01", c, gnt_o); else n_pass++;
         tick();
      end
      drain();
   endtask
`endif

   task automatic test_spurious();
      rstn = 1'b0; req = '0; lint_gnt = 1'b0; lint_rv = 1'b0;
      tick();
      rstn = 1'b1; req = 2'b01; lint_gnt = 1'b1;
      #1; tick();
      // Reset with one transaction outstanding; its response becomes spurious.
      rstn = 1'b0; req = '0; lint_gnt = 1'b0;
      tick();
      rstn = 1'b1; lint_rv = 1'b1; lint_rdata = {$urandom, $urandom};
      #1;
      n_total++; if (r_valid_o !== '0) $display("FAIL spur r_valid: got %b exp 00", r_valid_o); else n_pass++;
      n_total++; if (err_o !== 1'b0) $display("FAIL spur err_before: got %b exp 0", err_o); else n_pass++;
      tick();
      lint_rv = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_total++; if (err_o !== 1'b1) $display("FAIL spur err_held c%0d: got %b exp 1", c, err_o); else n_pass++;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rr = RR_START;
      m_err = 0;
      test_reset();
      test_single_read();
      test_fairness();
      test_grant_stall();
      test_full();
      test_ordering();
      test_random();
`ifdef ADBG_LINT_ARB_FIXED_PRIO0_EN
      test_fixed_prio();
`endif
      test_spurious();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
